// File: rtl/udp_vlg_tx_arb.sv
// Round-robin, per-datagram arbiter that merges N UDP TX sources onto one UDP TX port.
// Optional stall abort is enabled with `define UDP_VLG_TX_ARB_TIMEOUT_EN.
module udp_vlg_tx_arb #(
    parameter int N           = 4,
    parameter int META_W      = 80,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          in_rdy,
    input  logic [N*META_W-1:0]   in_meta,
    input  logic [N*8-1:0]        in_dat,
    input  logic [N-1:0]          in_val,
    input  logic [N-1:0]          in_sof,
    input  logic [N-1:0]          in_eof,
    input  logic [N-1:0]          in_err,
    output logic [N-1:0]          in_ack,
    output logic [N-1:0]          in_req,
    output logic [N-1:0]          in_done,
    output logic                  out_rdy,
    output logic [META_W-1:0]     out_meta,
    output logic [7:0]            out_dat,
    output logic                  out_val,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  out_err,
    input  logic                  out_ack,
    input  logic                  out_req,
    input  logic                  out_done,
    output logic [N-1:0]          grant,
    output logic                  timeout,
    output logic [1:0]            dbg_state
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HDR       = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // Handshake: a source holds in_rdy/in_meta until in_ack; in_ack, in_req and in_done
    // are combinational echoes of out_ack/out_req/out_done, routed to the granted channel only
    // and only in the state where that downstream signal is meaningful.
    logic [1:0]    state;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnext;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          abort;

    assign dbg_state = state;
    assign gnext     = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

    // First requesting channel at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!pick_vld && in_rdy[(int'(rr_ptr) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        in_ack  = '0;
        in_req  = '0;
        in_done = '0;
        case (state)
            HDR:       in_ack[gidx]  = out_ack;
            DATA:      in_req[gidx]  = out_req;
            WAIT_DONE: in_done[gidx] = out_done;
            default: ;
        endcase
    end

`ifdef UDP_VLG_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt;
    logic          progress;

    assign progress = ((state == HDR) && out_ack) ||
                      ((state == DATA) && in_val[gidx]) ||
                      ((state == WAIT_DONE) && out_done);
    // Fires on the TIMEOUT_CYC-th consecutive cycle without progress.
    assign abort = (state != IDLE) && !progress && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if ((state == IDLE) || progress || abort) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC != 0);
    assign abort      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gidx     <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            out_rdy  <= 1'b0;
            out_meta <= '0;
            out_dat  <= '0;
            out_val  <= 1'b0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
            out_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            out_val <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
            out_err <= 1'b0;
            out_dat <= '0;
            timeout <= abort;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gidx     <= pick_idx;
                        grant    <= N'(1) << pick_idx;
                        out_rdy  <= 1'b1;
                        out_meta <= in_meta[int'(pick_idx)*META_W +: META_W];
                        state    <= HDR;
                    end
                end
                HDR: begin
                    out_meta <= in_meta[int'(gidx)*META_W +: META_W];
                    if (out_ack) begin
                        out_rdy <= 1'b0;
                        state   <= DATA;
                    end else if (!in_rdy[gidx]) begin
                        // Source withdrew before the header was taken.
                        out_rdy <= 1'b0;
                        grant   <= '0;
                        rr_ptr  <= gnext;
                        state   <= IDLE;
                    end
                end
                DATA: begin
                    out_val <= in_val[gidx];
                    out_sof <= in_sof[gidx];
                    out_eof <= in_eof[gidx];
                    out_err <= in_err[gidx];
                    out_dat <= in_dat[int'(gidx)*8 +: 8];
                    if (in_val[gidx] && in_eof[gidx]) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (out_done) begin
                        grant  <= '0;
                        rr_ptr <= gnext;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (abort) begin
                // Terminate a stalled payload with an errored last beat so downstream closes it.
                if (state == DATA) begin
                    out_val <= 1'b1;
                    out_sof <= 1'b0;
                    out_eof <= 1'b1;
                    out_err <= 1'b1;
                    out_dat <= '0;
                end
                out_rdy <= 1'b0;
                grant   <= '0;
                rr_ptr  <= gnext;
                state   <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_udp_vlg_tx_arb.sv
// Directed bench for udp_vlg_tx_arb: single datagram, round-robin order, wrap, withdrawal, reset, stall abort.
module tb_udp_vlg_tx_arb;
    localparam int N  = 4;
    localparam int MW = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_rdy, in_val, in_sof, in_eof, in_err;
    logic [N*MW-1:0]   in_meta;
    logic [N*8-1:0]    in_dat;
    logic [N-1:0]      in_ack, in_req, in_done, grant;
    logic              out_rdy, out_val, out_sof, out_eof, out_err, timeout;
    logic [MW-1:0]     out_meta;
    logic [7:0]        out_dat;
    logic              out_ack, out_req, out_done;
    logic [1:0]        dbg_state;

    logic [10:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    udp_vlg_tx_arb #(.N(N), .META_W(MW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_rdy(in_rdy), .in_meta(in_meta), .in_dat(in_dat), .in_val(in_val),
        .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
        .in_ack(in_ack), .in_req(in_req), .in_done(in_done),
        .out_rdy(out_rdy), .out_meta(out_meta), .out_dat(out_dat), .out_val(out_val),
        .out_sof(out_sof), .out_eof(out_eof), .out_err(out_err),
        .out_ack(out_ack), .out_req(out_req), .out_done(out_done),
        .grant(grant), .timeout(timeout), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_meta(input int ch, input logic [MW-1:0] m);
        in_meta[ch*MW +: MW] = m;
    endtask

    task automatic wait_grant(input int ch, input logic [MW-1:0] m);
        logic [N-1:0] oh;
        int t;
        oh = 4'b0001 << ch;
        t = 0;
        while (grant == '0 && t < 8) begin
            tick();
            t++;
        end
        chk("grant", grant, oh);
        chk("out_rdy", out_rdy, 1'b1);
        chk("out_meta", out_meta, m);
    endtask

    // Full datagram on channel ch: header, len beats (junk driven on other channels), done.
    task automatic run_dg(input int ch, input int len, input logic [MW-1:0] m);
        logic [N-1:0] oh;
        logic [10:0]  e;
        oh = 4'b0001 << ch;
        wait_grant(ch, m);
        out_ack = 1'b1;
        #1 chk("in_ack", in_ack, oh);
        tick();
        out_ack    = 1'b0;
        in_rdy[ch] = 1'b0;
        chk("out_rdy_drop", out_rdy, 1'b0);
        chk("state_data", dbg_state, 2'd2);
        out_req = 1'b1;
        #1 chk("in_req", in_req, oh);
        for (int b = 0; b <= len; b++) begin
            if (b > 0) begin
                chk("out_val", out_val, 1'b1);
                e = exp_q.pop_front();
                chk("beat", {out_sof, out_eof, out_err, out_dat}, e);
            end
            if (b < len) begin
                in_val = '1;
                in_dat = {N{8'hEE}};
                in_sof = ~oh;
                in_eof = ~oh;
                in_err = ~oh;
                in_dat[ch*8 +: 8] = 8'(ch*16 + b);
                in_sof[ch] = (b == 0);
                in_eof[ch] = (b == len - 1);
                in_err[ch] = 1'b0;
                exp_q.push_back({(b == 0), (b == len - 1), 1'b0, 8'(ch*16 + b)});
                if (b == 1) begin
                    out_done = 1'b1;
                    out_ack  = 1'b1;
                    #1;
                    chk("stray_done", in_done, 4'b0000);
                    chk("stray_ack", in_ack, 4'b0000);
                end
            end else begin
                in_val = '0;
                in_sof = '0;
                in_eof = '0;
                in_err = '0;
            end
            tick();
            out_done = 1'b0;
            out_ack  = 1'b0;
        end
        out_req = 1'b0;
        chk("val_after_eof", out_val, 1'b0);
        chk("state_wait", dbg_state, 2'd3);
        out_done = 1'b1;
        #1 chk("in_done", in_done, oh);
        tick();
        out_done = 1'b0;
        chk("grant_idle", grant, 4'b0000);
        chk("state_idle", dbg_state, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_rdy = '0; in_val = '0; in_sof = '0; in_eof = '0; in_err = '0;
        in_meta = '0; in_dat = '0;
        out_ack = 1'b0; out_req = 1'b0; out_done = 1'b0;
        tick();
        tick();
        chk("rst_out_rdy", out_rdy, 1'b0);
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;

        // single datagram on ch1
        set_meta(1, 80'hC0A8_0001_1F90_1F91_0010);
        in_rdy[1] = 1'b1;
        tick();
        run_dg(1, 16, 80'hC0A8_0001_1F90_1F91_0010);

        // fresh pointer, all four ready at once
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) set_meta(c, {16'hA000 + 16'(c), 64'h0102_0304_0506_0708});
        in_rdy = 4'b1111;
        tick();
        run_dg(0, 3, {16'hA000, 64'h0102_0304_0506_0708});
        run_dg(1, 4, {16'hA001, 64'h0102_0304_0506_0708});
        run_dg(2, 5, {16'hA002, 64'h0102_0304_0506_0708});
        run_dg(3, 2, {16'hA003, 64'h0102_0304_0506_0708});

        // ch2 sends, then ch2+ch0 ready: pointer 3 wraps to ch0
        in_rdy[2] = 1'b1;
        tick();
        run_dg(2, 2, {16'hA002, 64'h0102_0304_0506_0708});
        in_rdy[2] = 1'b1;
        in_rdy[0] = 1'b1;
        tick();
        run_dg(0, 2, {16'hA000, 64'h0102_0304_0506_0708});
        run_dg(2, 3, {16'hA002, 64'h0102_0304_0506_0708});

        // ch1 withdraws before header ack; ch2 follows
        set_meta(1, 80'h1111_2222_3333_4444_5555);
        in_rdy[1] = 1'b1;
        tick();
        wait_grant(1, 80'h1111_2222_3333_4444_5555);
        in_rdy[1] = 1'b0;
        in_rdy[2] = 1'b1;
        #1 chk("withdraw_no_ack", in_ack, 4'b0000);
        tick();
        chk("withdraw_out_rdy", out_rdy, 1'b0);
        chk("withdraw_grant", grant, 4'b0000);
        run_dg(2, 3, {16'hA002, 64'h0102_0304_0506_0708});

        // reset during payload beat 5
        set_meta(0, 80'h0A0B_0C0D_0E0F_1011_1213);
        in_rdy[0] = 1'b1;
        tick();
        wait_grant(0, 80'h0A0B_0C0D_0E0F_1011_1213);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        out_req = 1'b1;
        for (int b = 0; b < 5; b++) begin
            in_val = 4'b0001;
            in_sof = (b == 0) ? 4'b0001 : 4'b0000;
            in_dat = {24'h0, 8'(8'h40 + b)};
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", out_val, 1'b0);
        chk("mid_rst_dat", out_dat, 8'h00);
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_req", in_req, 4'b0000);
        chk("mid_rst_state", dbg_state, 2'd0);
        in_val = '0; in_sof = '0; in_dat = '0;
        out_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_dg(0, 4, 80'h0A0B_0C0D_0E0F_1011_1213);

`ifdef UDP_VLG_TX_ARB_TIMEOUT_EN
        // ch3 stalls mid-payload for TIMEOUT_CYC cycles
        begin
            int t;
            set_meta(3, 80'h3333_0000_3333_0000_3333);
            in_rdy[3] = 1'b1;
            tick();
            wait_grant(3, 80'h3333_0000_3333_0000_3333);
            out_ack = 1'b1;
            tick();
            out_ack   = 1'b0;
            in_rdy[3] = 1'b0;
            out_req   = 1'b1;
            for (int b = 0; b < 2; b++) begin
                in_val = 4'b1000;
                in_sof = (b == 0) ? 4'b1000 : 4'b0000;
                in_dat = {8'(8'h70 + b), 24'h0};
                tick();
            end
            in_val = '0; in_sof = '0; in_dat = '0;
            t = 0;
            while (!timeout && t < 16) begin
                tick();
                t++;
            end
            chk("timeout_cycles", t, 8);
            chk("abort_beat", {out_val, out_sof, out_eof, out_err, out_dat}, {4'b1011, 8'h00});
            chk("abort_grant", grant, 4'b0000);
            out_req  = 1'b0;
            out_done = 1'b1;
            #1 chk("abort_no_done", in_done, 4'b0000);
            tick();
            out_done = 1'b0;
            chk("timeout_pulse_end", timeout, 1'b0);
            chk("abort_val_end", out_val, 1'b0);
            chk("abort_state", dbg_state, 2'd0);
        end
`else
        chk("timeout_tied", timeout, 1'b0);
`endif

        chk("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
